// File: rtl/approximate_adder_error_monitor.sv
// Response-side checker for approximate adders: recomputes A+B+cin for each
// accepted sample and accumulates error statistics over a programmed run length.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, n_target       begin a run of n_target samples (honoured in IDLE/DONE)
//   in_valid, in_ready    sample handshake
//   A, B, cin, sum, cout  operands and the approximate result under test
//   samples, err_count    accepted samples / erroneous samples this run
//   err_dist_sum          saturating sum of |exact - approx|
//   max_err_dist          largest |exact - approx| this run
//   busy, done            run in progress / results final
module approximate_adder_error_monitor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned ACC_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   n_target,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               cin,
  input  logic [WIDTH-1:0]   sum,
  input  logic               cout,
  output logic [CNT_W-1:0]   samples,
  output logic [CNT_W-1:0]   err_count,
  output logic [ACC_W-1:0]   err_dist_sum,
  output logic [WIDTH:0]     max_err_dist,
  output logic               busy,
  output logic               done
);

  localparam int unsigned RES_W = WIDTH + 1;
  // Accumulator addition is done one bit wider than either operand so the
  // saturation test sees the true sum even when ACC_W < RES_W.
  localparam int unsigned SUM_W = ((ACC_W > RES_W) ? ACC_W : RES_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] n_lat;
  logic             s1_valid;
  logic [RES_W-1:0] s1_dist;

  logic             accept_c;
  logic             start_ok_c;
  logic [RES_W-1:0] exact_c, approx_c, dist_c;
  logic [SUM_W-1:0] acc_ext_c;
  logic [ACC_W-1:0] acc_next_c;

  assign accept_c = in_valid & in_ready;

  // Stage-1 arithmetic and stage-2 saturating accumulate
  always_comb begin
    exact_c    = RES_W'(A) + RES_W'(B) + RES_W'(cin);
    approx_c   = {cout, sum};
    dist_c     = (exact_c >= approx_c) ? (exact_c - approx_c) : (approx_c - exact_c);
    acc_ext_c  = SUM_W'(err_dist_sum) + SUM_W'(s1_dist);
    acc_next_c = (acc_ext_c > SUM_W'(ACC_MAX)) ? ACC_MAX : ACC_W'(acc_ext_c);
  end

  // Next-state logic
  always_comb begin
    state_d    = state;
    start_ok_c = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_ok_c = 1'b1;
          state_d    = (n_target == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (accept_c && ((samples + CNT_W'(1)) == n_lat)) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Status outputs registered from the next state so they align with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      in_ready <= (state_d == S_RUN);
      busy     <= (state_d == S_RUN) || (state_d == S_DRAIN);
      done     <= (state_d == S_DONE);
    end
  end

  // Run length, sample counter and stage-1 pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_lat    <= '0;
      samples  <= '0;
      s1_valid <= 1'b0;
      s1_dist  <= '0;
    end else begin
      s1_valid <= accept_c;
      if (accept_c) s1_dist <= dist_c;
      if (start_ok_c) begin
        n_lat   <= n_target;
        samples <= '0;
      end else if (accept_c) begin
        samples <= samples + CNT_W'(1);
      end
    end
  end

  // Stage-2 statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count    <= '0;
      err_dist_sum <= '0;
      max_err_dist <= '0;
    end else if (start_ok_c) begin
      err_count    <= '0;
      err_dist_sum <= '0;
      max_err_dist <= '0;
    end else if (s1_valid) begin
      if (s1_dist != '0) err_count <= err_count + CNT_W'(1);
      err_dist_sum <= acc_next_c;
      if (s1_dist > max_err_dist) max_err_dist <= s1_dist;
    end
  end

endmodule

// File: tb/tb_approximate_adder_error_monitor.sv
// Directed bench: table of per-sample vectors with running expected statistics,
// plus hand sequences for back-to-back accepts, zero-length runs, reset and restart.
// A second instance with ACC_W=4 shares all stimulus to exercise saturation.
module tb_approximate_adder_error_monitor;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] n_target;
  logic          in_valid;
  logic [W-1:0]  a, b, s;
  logic          ci, co;

  logic          in_ready, busy, done;
  logic [CW-1:0] samples, err_count;
  logic [AW-1:0] err_dist_sum;
  logic [W:0]    max_err_dist;

  logic          in_ready4, busy4, done4;
  logic [CW-1:0] samples4, err_count4;
  logic [3:0]    err_dist_sum4;
  logic [W:0]    max_err_dist4;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  approximate_adder_error_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(AW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .n_target(n_target),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .cin(ci), .sum(s), .cout(co),
    .samples(samples), .err_count(err_count), .err_dist_sum(err_dist_sum),
    .max_err_dist(max_err_dist), .busy(busy), .done(done)
  );

  approximate_adder_error_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start), .n_target(n_target),
    .in_valid(in_valid), .in_ready(in_ready4),
    .A(a), .B(b), .cin(ci), .sum(s), .cout(co),
    .samples(samples4), .err_count(err_count4), .err_dist_sum(err_dist_sum4),
    .max_err_dist(max_err_dist4), .busy(busy4), .done(done4)
  );

  typedef struct {
    logic        new_run;
    logic [15:0] n;
    logic [7:0]  a, b;
    logic        ci;
    logic [7:0]  s;
    logic        co;
    int          e_smp, e_cnt, e_sum, e_max, e_sum4;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Pulse start for one cycle; returns at the negedge after the start edge
  task automatic start_run(input logic [15:0] n);
    @(negedge clk);
    start    = 1'b1;
    n_target = n;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Present one sample after gap idle cycles; returns at the negedge after its accept edge
  task automatic send(input int gap, input logic [7:0] va, input logic [7:0] vb,
                      input logic vci, input logic [7:0] vs, input logic vco);
    int waited;
    repeat (gap) @(negedge clk);
    a = va; b = vb; ci = vci; s = vs; co = vco;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL accept_timeout: in_ready stayed %0d, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 16'd3,  8'd65,  8'd76, 1'b0, 8'd141, 1'b0, 1, 0, 0,  0, 0};
    vecs[1] = '{1'b0, 16'd3,  8'd71,  8'd66, 1'b0, 8'd137, 1'b0, 2, 0, 0,  0, 0};
    vecs[2] = '{1'b0, 16'd3,  8'd84,  8'd73, 1'b0, 8'd157, 1'b0, 3, 0, 0,  0, 0};
    vecs[3] = '{1'b1, 16'd2,  8'd200, 8'd100, 1'b0, 8'd40, 1'b1, 1, 1, 4,  4, 4};
    vecs[4] = '{1'b0, 16'd2,  8'd1,   8'd1,  1'b0, 8'd0,   1'b0, 2, 2, 6,  4, 6};
    vecs[5] = '{1'b1, 16'd2,  8'd0,   8'd0,  1'b0, 8'd9,   1'b0, 1, 1, 9,  9, 9};
    vecs[6] = '{1'b0, 16'd2,  8'd100, 8'd0,  1'b0, 8'd91,  1'b0, 2, 2, 18, 9, 15};

    rst = 1'b1; start = 1'b0; n_target = '0; in_valid = 1'b0;
    a = '0; b = '0; ci = 1'b0; s = '0; co = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_samples", 32'(samples), 0);
    chk("rst_err_sum", 32'(err_dist_sum), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 0);

    // Table: exact samples, erroneous samples, saturation
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].new_run) start_run(vecs[i].n);
      send(0, vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co);
      @(negedge clk);
      chk($sformatf("v%0d_samples", i), 32'(samples), vecs[i].e_smp);
      chk($sformatf("v%0d_err_count", i), 32'(err_count), vecs[i].e_cnt);
      chk($sformatf("v%0d_err_sum", i), 32'(err_dist_sum), vecs[i].e_sum);
      chk($sformatf("v%0d_max", i), 32'(max_err_dist), vecs[i].e_max);
      chk($sformatf("v%0d_sat_sum", i), 32'(err_dist_sum4), vecs[i].e_sum4);
      if (vecs[i].e_smp == int'(vecs[i].n)) chk($sformatf("v%0d_done", i), 32'(done), 1);
      else                                  chk($sformatf("v%0d_busy", i), 32'(busy), 1);
    end

    // in_valid while not ready is ignored
    a = 8'd3; b = 8'd3; ci = 1'b0; s = 8'd0; co = 1'b0;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("ignore_samples", 32'(samples), 2);
    chk("ignore_err_sum", 32'(err_dist_sum), 18);

    // Zero-length run
    start_run(16'd0);
    chk("n0_done", 32'(done), 1);
    chk("n0_in_ready", 32'(in_ready), 0);
    chk("n0_samples", 32'(samples), 0);
    chk("n0_err_count", 32'(err_count), 0);
    chk("n0_err_sum", 32'(err_dist_sum), 0);
    chk("n0_max", 32'(max_err_dist), 0);
    @(negedge clk);
    chk("n0_in_ready_later", 32'(in_ready), 0);

    // Back-to-back accepts, one per cycle
    start_run(16'd3);
    chk("b2b_in_ready", 32'(in_ready), 1);
    a = 8'd10;  b = 8'd20;  ci = 1'b0; s = 8'd30;  co = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 8'd10;  b = 8'd20;  ci = 1'b1; s = 8'd30;  co = 1'b0;
    @(negedge clk);
    a = 8'd255; b = 8'd255; ci = 1'b1; s = 8'd255; co = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_samples", 32'(samples), 3);
    chk("b2b_drain_busy", 32'(busy), 1);
    chk("b2b_drain_done", 32'(done), 0);
    chk("b2b_drain_in_ready", 32'(in_ready), 0);
    chk("b2b_partial_sum", 32'(err_dist_sum), 1);
    @(negedge clk);
    chk("b2b_done", 32'(done), 1);
    chk("b2b_err_count", 32'(err_count), 2);
    chk("b2b_err_sum", 32'(err_dist_sum), 257);
    chk("b2b_max", 32'(max_err_dist), 256);

    // Gapped run aborted by reset, then a fresh run
    start_run(16'd4);
    send(0, 8'd10, 8'd20, 1'b0, 8'd30, 1'b0);
    send(2, 8'd10, 8'd20, 1'b1, 8'd30, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_samples", 32'(samples), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_err_sum", 32'(err_dist_sum), 0);
    chk("post_rst_err_count", 32'(err_count), 0);
    chk("post_rst_done", 32'(done), 0);
    start_run(16'd1);
    send(3, 8'd200, 8'd100, 1'b0, 8'd40, 1'b1);
    @(negedge clk);
    chk("rerun_done", 32'(done), 1);
    chk("rerun_samples", 32'(samples), 1);
    chk("rerun_err_sum", 32'(err_dist_sum), 4);
    chk("rerun_max", 32'(max_err_dist), 4);

    // start during RUN is ignored; start in DONE restarts
    start_run(16'd2);
    send(1, 8'd1, 8'd1, 1'b0, 8'd0, 1'b0);
    start_run(16'd0);
    chk("ign_start_busy", 32'(busy), 1);
    chk("ign_start_done", 32'(done), 0);
    send(0, 8'd0, 8'd0, 1'b0, 8'd9, 1'b0);
    @(negedge clk);
    chk("ign_start_final_done", 32'(done), 1);
    chk("ign_start_samples", 32'(samples), 2);
    chk("ign_start_err_sum", 32'(err_dist_sum), 11);
    chk("ign_start_max", 32'(max_err_dist), 9);
    start_run(16'd1);
    chk("restart_done", 32'(done), 0);
    chk("restart_samples", 32'(samples), 0);
    chk("restart_err_count", 32'(err_count), 0);
    chk("restart_err_sum", 32'(err_dist_sum), 0);
    chk("restart_max", 32'(max_err_dist), 0);
    chk("restart_in_ready", 32'(in_ready), 1);
    send(0, 8'd65, 8'd76, 1'b0, 8'd141, 1'b0);
    @(negedge clk);
    chk("restart_final_done", 32'(done), 1);
    chk("restart_final_samples", 32'(samples), 1);
    chk("restart_final_err", 32'(err_count), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
